// File: rtl/multicycle_ctrl_if.sv
// Control/handshake bundle between the multi-cycle sequencer and its datapath.
// master: the sequencer (drives requests, strobes and status).
// slave : the datapath/memory side (drives run, instr, a0 and the ready inputs).
interface multicycle_ctrl_if;
  logic        run;
  logic [31:0] instr;
  logic [31:0] a0;
  logic        imem_ready;
  logic        dmem_ready;

  logic        imem_req;
  logic        dmem_req;
  logic        dmem_we;
  logic        ir_we;
  logic        pc_we;
  logic        rf_we;
  logic        ecall_print;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic [31:0] instret;

  modport master (
    input  run, instr, a0, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, ecall_print,
    output halted, trap_cause, state, cycle_count, instret
  );

  modport slave (
    output run, instr, a0, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, ecall_print,
    input  halted, trap_cause, state, cycle_count, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB,
// write-strobe gating, memory ready handshakes with timeout, ECALL service,
// sticky halt/trap status and cycle/retired-instruction counters.
// Ports: clock, reset (sync, active-high); bus (multicycle_ctrl_if.master)
//   inputs : run, instr, a0, imem_ready, dmem_ready
//   strobes: imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, ecall_print
//            (combinational from state, readies and instr)
//   status : halted, trap_cause, state, cycle_count, instret (registered)
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;
  localparam logic [31:0] ECALL_W   = 32'h0000_0073;
  localparam logic [31:0] A0_EXIT   = 32'd10;
  localparam logic [31:0] A0_PRINT  = 32'd1;

  localparam logic [1:0]  CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'd2;

  // Wait counter value on the last tolerated not-ready cycle.
  localparam logic [7:0]  WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        halted_q, halted_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, ecall_print;

  // Instruction classification.
  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, is_ecall, is_legal_op, rd_zero;

  always_comb begin
    opcode      = bus.instr[6:0];
    is_load     = (opcode == OP_LOAD);
    is_store    = (opcode == OP_STORE);
    is_branch   = (opcode == OP_BRANCH);
    is_ecall    = (bus.instr == ECALL_W);
    rd_zero     = (bus.instr[11:7] == 5'd0);
    is_legal_op = (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                  (opcode == OP_JAL)  || (opcode == OP_JALR)  ||
                  is_branch || is_load || is_store ||
                  (opcode == OP_IMM)  || (opcode == OP_OP);
  end

  // Next-state and strobe logic. Wait counter defaults to 0 so every
  // state entry starts a fresh timeout window.
  always_comb begin
    state_d     = state_q;
    wait_d      = 8'd0;
    halted_d    = halted_q;
    cause_d     = cause_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    rf_we       = 1'b0;
    ecall_print = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        if (is_ecall) begin
          if (bus.a0 == A0_EXIT) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            pc_we       = 1'b1;
            ecall_print = (bus.a0 == A0_PRINT);
            state_d     = S_FETCH;
          end
        end else if (is_legal_op) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (bus.dmem_ready) begin
          if (is_store) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        pc_we   = 1'b1;
        rf_we   = !is_branch && !rd_zero;
        state_d = S_FETCH;
      end
      default: begin
        // HALT and TRAP are absorbing until reset.
      end
    endcase

    cycle_d   = cycle_q + ((state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) ? 32'd1 : 32'd0);
    instret_d = instret_q + 32'(pc_we);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      wait_q    <= 8'd0;
      halted_q  <= 1'b0;
      cause_q   <= 2'd0;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      cause_q   <= cause_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are suppressed during reset so an abandoned access never commits.
  assign bus.imem_req    = imem_req    & ~reset;
  assign bus.dmem_req    = dmem_req    & ~reset;
  assign bus.dmem_we     = dmem_we     & ~reset;
  assign bus.ir_we       = ir_we       & ~reset;
  assign bus.pc_we       = pc_we       & ~reset;
  assign bus.rf_we       = rf_we       & ~reset;
  assign bus.ecall_print = ecall_print & ~reset;

  assign bus.halted      = halted_q;
  assign bus.trap_cause  = cause_q;
  assign bus.state       = 3'(state_q);
  assign bus.cycle_count = cycle_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl: the driver pushes one
// hand-computed expectation per cycle; the negedge monitor pops and compares.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [2:0]  st;
    logic [6:0]  s;   // {imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, ecall_print}
    logic        h;
    logic [1:0]  tc;
    logic [31:0] ic;
    logic [31:0] cc;
  } exp_t;

  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_2103;
  localparam logic [31:0] SW    = 32'h0020_2223;
  localparam logic [31:0] BEQ   = 32'h0000_0063;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  localparam logic [6:0] Z   = 7'b0000000;
  localparam logic [6:0] F   = 7'b1100000;
  localparam logic [6:0] FW  = 7'b1000000;
  localparam logic [6:0] M   = 7'b0010000;
  localparam logic [6:0] MS  = 7'b0011100;
  localparam logic [6:0] WBR = 7'b0000110;
  localparam logic [6:0] WBB = 7'b0000100;
  localparam logic [6:0] EP  = 7'b0000101;

  logic clock;
  logic reset;
  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   idx        = 0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of inputs and queue the expected observation for it.
  task automatic cyc(input logic rst, input logic run, input logic [31:0] ins,
                     input logic [31:0] a0, input logic ir, input logic dr,
                     input logic [2:0] st, input logic [6:0] s, input logic h,
                     input logic [1:0] tc, input logic [31:0] ic, input logic [31:0] cc);
    exp_t e;
    @(posedge clock);
    #1;
    reset          = rst;
    bus.run        = run;
    bus.instr      = ins;
    bus.a0         = a0;
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    e.st = st; e.s = s; e.h = h; e.tc = tc; e.ic = ic; e.cc = cc;
    exp_q.push_back(e);
  endtask

  // Immediate directed check.
  task automatic chk(input logic ok, input string what);
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("FAIL %s: st=%0d tc=%0d halt=%b ir=%0d cc=%0d",
               what, bus.state, bus.trap_cause, bus.halted, bus.instret, bus.cycle_count);
    end
  endtask

  // Monitor: compare DUT outputs against the next queued expectation.
  always @(negedge clock) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      got.st = bus.state;
      got.s  = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
                bus.pc_we, bus.rf_we, bus.ecall_print};
      got.h  = bus.halted;
      got.tc = bus.trap_cause;
      got.ic = bus.instret;
      got.cc = bus.cycle_count;
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL cyc%0d: got st=%0d strb=%b halt=%b tc=%0d ir=%0d cc=%0d, want st=%0d strb=%b halt=%b tc=%0d ir=%0d cc=%0d",
                 idx, got.st, got.s, got.h, got.tc, got.ic, got.cc,
                 e.st, e.s, e.h, e.tc, e.ic, e.cc);
      end
      idx++;
    end
  end

  initial begin
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.instr      = 32'd0;
    bus.a0         = 32'd0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk(bus.state == 3'd0 && bus.halted == 1'b0 && bus.trap_cause == 2'd0 &&
        bus.cycle_count == 32'd0 && bus.instret == 32'd0 &&
        {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we,
         bus.pc_we, bus.rf_we, bus.ecall_print} == 7'd0,
        "reset state");

    // addi x1,x0,5 with zero-wait memory
    cyc(0, 1, ADDI, 0, 1, 1,  3'd0, Z,   0, 0, 0, 0);
    cyc(0, 1, ADDI, 0, 1, 1,  3'd1, F,   0, 0, 0, 0);
    cyc(0, 0, ADDI, 0, 1, 1,  3'd2, Z,   0, 0, 0, 1);
    cyc(0, 0, ADDI, 0, 1, 1,  3'd3, Z,   0, 0, 0, 2);
    cyc(0, 0, ADDI, 0, 1, 1,  3'd5, WBR, 0, 0, 0, 3);
    // lw x2,0(x0), dmem not ready for 3 cycles
    cyc(0, 0, LW,   0, 1, 0,  3'd1, F,   0, 0, 1, 4);
    cyc(0, 0, LW,   0, 1, 0,  3'd2, Z,   0, 0, 1, 5);
    cyc(0, 0, LW,   0, 1, 0,  3'd3, Z,   0, 0, 1, 6);
    cyc(0, 0, LW,   0, 1, 0,  3'd4, M,   0, 0, 1, 7);
    cyc(0, 0, LW,   0, 1, 0,  3'd4, M,   0, 0, 1, 8);
    cyc(0, 0, LW,   0, 1, 0,  3'd4, M,   0, 0, 1, 9);
    cyc(0, 0, LW,   0, 1, 1,  3'd4, M,   0, 0, 1, 10);
    cyc(0, 0, LW,   0, 1, 1,  3'd5, WBR, 0, 0, 1, 11);
    // sw x2,4(x0)
    cyc(0, 0, SW,   0, 1, 1,  3'd1, F,   0, 0, 2, 12);
    cyc(0, 0, SW,   0, 1, 1,  3'd2, Z,   0, 0, 2, 13);
    cyc(0, 0, SW,   0, 1, 1,  3'd3, Z,   0, 0, 2, 14);
    cyc(0, 0, SW,   0, 1, 1,  3'd4, MS,  0, 0, 2, 15);
    // beq: WB without register write
    cyc(0, 0, BEQ,  0, 1, 1,  3'd1, F,   0, 0, 3, 16);
    cyc(0, 0, BEQ,  0, 1, 1,  3'd2, Z,   0, 0, 3, 17);
    cyc(0, 0, BEQ,  0, 1, 1,  3'd3, Z,   0, 0, 3, 18);
    cyc(0, 0, BEQ,  0, 1, 1,  3'd5, WBB, 0, 0, 3, 19);
    // ECALL print
    cyc(0, 0, ECALL, 1, 1, 1, 3'd1, F,   0, 0, 4, 20);
    cyc(0, 0, ECALL, 1, 1, 1, 3'd2, EP,  0, 0, 4, 21);
    // ECALL exit, then run toggling in HALT
    cyc(0, 0, ECALL, 10, 1, 1, 3'd1, F,  0, 0, 5, 22);
    cyc(0, 0, ECALL, 10, 1, 1, 3'd2, Z,  0, 0, 5, 23);
    cyc(0, 1, ECALL, 10, 1, 1, 3'd6, Z,  1, 0, 5, 24);
    cyc(0, 0, ECALL, 10, 1, 1, 3'd6, Z,  1, 0, 5, 24);
    cyc(0, 1, ECALL, 10, 1, 1, 3'd6, Z,  1, 0, 5, 24);
    // reset out of HALT, then fetch timeout
    cyc(1, 0, ADDI, 0, 0, 0,  3'd6, Z,   1, 0, 5, 24);
    cyc(0, 1, ADDI, 0, 0, 0,  3'd0, Z,   0, 0, 0, 0);
    for (int k = 0; k < 16; k++)
      cyc(0, 1, ADDI, 0, 0, 0, 3'd1, FW, 0, 0, 0, 32'(k));
    cyc(0, 1, ADDI, 0, 1, 1,  3'd7, Z,   0, 2, 0, 16);
    chk(bus.state == 3'd7 && bus.trap_cause == 2'd2 && bus.imem_req == 1'b0 &&
        bus.cycle_count == 32'd16,
        "expired fetch wait");
    cyc(0, 1, ADDI, 0, 1, 1,  3'd7, Z,   0, 2, 0, 16);
    // illegal all-zero instruction
    cyc(1, 0, 32'd0, 0, 1, 1, 3'd7, Z,   0, 2, 0, 16);
    cyc(0, 1, 32'd0, 0, 1, 1, 3'd0, Z,   0, 0, 0, 0);
    cyc(0, 1, 32'd0, 0, 1, 1, 3'd1, F,   0, 0, 0, 0);
    cyc(0, 1, 32'd0, 0, 1, 1, 3'd2, Z,   0, 0, 0, 1);
    cyc(0, 1, 32'd0, 0, 1, 1, 3'd7, Z,   0, 1, 0, 2);
    // reset while a load waits in MEM
    cyc(1, 0, LW,   0, 1, 0,  3'd7, Z,   0, 1, 0, 2);
    cyc(0, 1, LW,   0, 1, 0,  3'd0, Z,   0, 0, 0, 0);
    cyc(0, 0, LW,   0, 1, 0,  3'd1, F,   0, 0, 0, 0);
    cyc(0, 0, LW,   0, 1, 0,  3'd2, Z,   0, 0, 0, 1);
    cyc(0, 0, LW,   0, 1, 0,  3'd3, Z,   0, 0, 0, 2);
    cyc(0, 0, LW,   0, 1, 0,  3'd4, M,   0, 0, 0, 3);
    cyc(1, 0, LW,   0, 1, 1,  3'd4, Z,   0, 0, 0, 4);
    cyc(0, 0, LW,   0, 1, 1,  3'd0, Z,   0, 0, 0, 0);
    cyc(0, 0, LW,   0, 1, 1,  3'd0, Z,   0, 0, 0, 0);

    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
